// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for the shared 6-bit ALU.
// Registers the granted command, captures the ALU result one cycle later and returns it tagged.
module alu_share_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [5:0] req0_a,
    input  logic [5:0] req0_b,
    input  logic       req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [5:0] req1_a,
    input  logic [5:0] req1_b,
    input  logic       req1_op,
    output logic [5:0] alu_a,
    output logic [5:0] alu_b,
    output logic       alu_op,
    input  logic [5:0] alu_r,
    input  logic       alu_cf,
    input  logic       alu_sf,
    input  logic       alu_zf,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [5:0] rsp_r,
    output logic       rsp_cf,
    output logic       rsp_sf,
    output logic       rsp_zf
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       last_grant_q;
    logic       grant0;
    logic       grant1;
    logic       accept;

    logic [5:0] alu_a_q;
    logic [5:0] alu_b_q;
    logic       alu_op_q;
    logic       rsp_id_q;
    logic [5:0] rsp_r_q;
    logic       rsp_cf_q;
    logic       rsp_sf_q;
    logic       rsp_zf_q;

    // Under contention the requester that did not win last time is served.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rst_n && (grant0 || grant1)) begin
                    accept     = 1'b1;
                    req0_ready = grant0;
                    req1_ready = grant1;
                    state_d    = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            alu_a_q      <= 6'd0;
            alu_b_q      <= 6'd0;
            alu_op_q     <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_r_q      <= 6'd0;
            rsp_cf_q     <= 1'b0;
            rsp_sf_q     <= 1'b0;
            rsp_zf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant1;
                rsp_id_q     <= grant1;
                alu_a_q      <= grant1 ? req1_a : req0_a;
                alu_b_q      <= grant1 ? req1_b : req0_b;
                alu_op_q     <= grant1 ? req1_op : req0_op;
            end
            // ALU inputs have been stable for a full cycle by the end of EXEC.
            if (state_q == StExec) begin
                rsp_r_q  <= alu_r;
                rsp_cf_q <= alu_cf;
                rsp_sf_q <= alu_sf;
                rsp_zf_q <= alu_zf;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_cf    = rsp_cf_q;
    assign rsp_sf    = rsp_sf_q;
    assign rsp_zf    = rsp_zf_q;

endmodule
